rx_cmd_parser: RTL and testbench

RX_CMD_PARSER -- requirements
Module: rx_cmd_parser

---
 rtl/rx_cmd_parser.sv | 147 ++++++++++++++
 tb/tb_rx_cmd_parser.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/rx_cmd_parser.sv
// Parses UART command frames (write / read / ALU / NOP) into register-file and ALU strobes.
// Latency: strobes one cycle after the accepting byte; no backpressure, inter-byte timeout aborts frames.
module rx_cmd_parser #(
  parameter int TIMEOUT = 4096
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] RX_P_DATA,
  input  logic       RX_D_VLD,
  input  logic       RX_ERR,
  output logic       WrEn,
  output logic       RdEn,
  output logic [3:0] Address,
  output logic [7:0] WrData,
  output logic       ALU_EN,
  output logic [3:0] ALU_FUN,
  output logic       busy,
  output logic       frm_err,
  output logic       unk_cmd
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_DATA = 3'd2,
    RD_ADDR = 3'd3,
    ALU_A   = 3'd4,
    ALU_B   = 3'd5,
    ALU_FN  = 3'd6,
    NOP_FUN = 3'd7
  } state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t      state_q;
  logic [15:0] cnt_q;
  logic [3:0]  wr_addr_q;
  logic        wr_en_q, rd_en_q, alu_en_q, busy_q, frm_err_q, unk_cmd_q;
  logic [3:0]  addr_q, alu_fun_q;
  logic [7:0]  wr_data_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wr_addr_q <= '0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      alu_en_q  <= 1'b0;
      busy_q    <= 1'b0;
      frm_err_q <= 1'b0;
      unk_cmd_q <= 1'b0;
      addr_q    <= '0;
      wr_data_q <= '0;
      alu_fun_q <= '0;
    end else begin
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      alu_en_q  <= 1'b0;
      frm_err_q <= 1'b0;
      unk_cmd_q <= 1'b0;
      if (state_q == IDLE) begin
        cnt_q <= '0;
        if (RX_D_VLD && !RX_ERR) begin
          busy_q <= 1'b1;
          case (RX_P_DATA)
            8'hAA:   state_q <= WR_ADDR;
            8'hBB:   state_q <= RD_ADDR;
            8'hCC:   state_q <= ALU_A;
            8'hDD:   state_q <= NOP_FUN;
            default: begin
              busy_q    <= 1'b0;
              unk_cmd_q <= 1'b1;
            end
          endcase
        end
      end else if (RX_D_VLD && RX_ERR) begin
        state_q   <= IDLE;
        busy_q    <= 1'b0;
        frm_err_q <= 1'b1;
        cnt_q     <= '0;
      end else if (RX_D_VLD) begin
        // A valid byte wins over a timeout landing in the same cycle.
        cnt_q <= '0;
        case (state_q)
          WR_ADDR: begin
            wr_addr_q <= RX_P_DATA[3:0];
            state_q   <= WR_DATA;
          end
          WR_DATA: begin
            wr_en_q   <= 1'b1;
            addr_q    <= wr_addr_q;
            wr_data_q <= RX_P_DATA;
            state_q   <= IDLE;
            busy_q    <= 1'b0;
          end
          RD_ADDR: begin
            rd_en_q <= 1'b1;
            addr_q  <= RX_P_DATA[3:0];
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
          ALU_A: begin
            wr_en_q   <= 1'b1;
            addr_q    <= 4'd0;
            wr_data_q <= RX_P_DATA;
            state_q   <= ALU_B;
          end
          ALU_B: begin
            wr_en_q   <= 1'b1;
            addr_q    <= 4'd1;
            wr_data_q <= RX_P_DATA;
            state_q   <= ALU_FN;
          end
          ALU_FN, NOP_FUN: begin
            alu_en_q  <= 1'b1;
            alu_fun_q <= RX_P_DATA[3:0];
            state_q   <= IDLE;
            busy_q    <= 1'b0;
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end else if (cnt_q == TO_LAST) begin
        state_q   <= IDLE;
        busy_q    <= 1'b0;
        frm_err_q <= 1'b1;
        cnt_q     <= '0;
      end else begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

  assign WrEn    = wr_en_q;
  assign RdEn    = rd_en_q;
  assign ALU_EN  = alu_en_q;
  assign Address = addr_q;
  assign WrData  = wr_data_q;
  assign ALU_FUN = alu_fun_q;
  assign busy    = busy_q;
  assign frm_err = frm_err_q;
  assign unk_cmd = unk_cmd_q;

endmodule

// File: tb/tb_rx_cmd_parser.sv
// Random and directed command frames against a frame-level reference model; scoreboard of output events.
module tb_rx_cmd_parser;
  localparam int TO = 16;

  logic       CLK, RST;
  logic [7:0] RX_P_DATA;
  logic       RX_D_VLD, RX_ERR;
  logic       WrEn, RdEn, ALU_EN, busy, frm_err, unk_cmd;
  logic [3:0] Address, ALU_FUN;
  logic [7:0] WrData;

  rx_cmd_parser #(.TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD), .RX_ERR(RX_ERR),
    .WrEn(WrEn), .RdEn(RdEn), .Address(Address), .WrData(WrData), .ALU_EN(ALU_EN),
    .ALU_FUN(ALU_FUN), .busy(busy), .frm_err(frm_err), .unk_cmd(unk_cmd)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Event vector bit order: {WrEn, RdEn, ALU_EN, frm_err, unk_cmd}
  localparam logic [4:0] EV_WR = 5'b10000, EV_RD = 5'b01000, EV_ALU = 5'b00100,
                         EV_FRM = 5'b00010, EV_UNK = 5'b00001;
  typedef struct { logic [4:0] vec; int cyc; } ev_t;
  ev_t sb[$];

  int checks = 0, errors = 0, cyc = 0;

  // Reference model: pending frame bytes and idle-cycle count since last accepted byte.
  logic [7:0] pend[$];
  int         gap = 0;
  logic       m_busy = 1'b0;
  logic [3:0] m_addr = '0, m_fun = '0;
  logic [7:0] m_wd = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic push_ev(input logic [4:0] v);
    ev_t e;
    e.vec = v;
    e.cyc = cyc;
    sb.push_back(e);
  endtask

  task automatic frame_byte();
    int n;
    logic [7:0] op, b, a;
    n  = pend.size();
    op = pend[0];
    b  = pend[n-1];
    case (op)
      8'hAA: if (n == 3) begin
        a = pend[1];
        m_addr = a[3:0]; m_wd = b; push_ev(EV_WR); pend.delete();
      end
      8'hBB: begin m_addr = b[3:0]; push_ev(EV_RD); pend.delete(); end
      8'hCC: begin
        if (n == 2) begin m_addr = 4'd0; m_wd = b; push_ev(EV_WR); end
        else if (n == 3) begin m_addr = 4'd1; m_wd = b; push_ev(EV_WR); end
        else begin m_fun = b[3:0]; push_ev(EV_ALU); pend.delete(); end
      end
      default: begin m_fun = b[3:0]; push_ev(EV_ALU); pend.delete(); end
    endcase
  endtask

  always @(posedge CLK) begin
    cyc++;
    if (RST) begin
      pend.delete(); gap = 0; m_addr = '0; m_wd = '0; m_fun = '0;
    end else if (pend.size() == 0) begin
      gap = 0;
      if (RX_D_VLD && !RX_ERR) begin
        if (RX_P_DATA inside {8'hAA, 8'hBB, 8'hCC, 8'hDD}) pend.push_back(RX_P_DATA);
        else push_ev(EV_UNK);
      end
    end else if (RX_D_VLD && RX_ERR) begin
      pend.delete(); push_ev(EV_FRM);
    end else if (RX_D_VLD) begin
      gap = 0; pend.push_back(RX_P_DATA); frame_byte();
    end else begin
      gap++;
      if (gap == TO) begin pend.delete(); push_ev(EV_FRM); end
    end
    m_busy = (pend.size() != 0);
  end

  // Monitor: compares held outputs each cycle and pops the scoreboard on any strobe.
  always @(negedge CLK) begin
    logic [4:0] act;
    ev_t e;
    if (cyc > 0) begin
      chk("busy", 32'(busy), 32'(m_busy));
      chk("Address", 32'(Address), 32'(m_addr));
      chk("WrData", 32'(WrData), 32'(m_wd));
      chk("ALU_FUN", 32'(ALU_FUN), 32'(m_fun));
      while (sb.size() != 0 && sb[0].cyc < cyc) begin
        e = sb.pop_front();
        chk("missing_event", 32'(0), 32'(e.vec));
      end
      act = {WrEn, RdEn, ALU_EN, frm_err, unk_cmd};
      if (act !== 5'b0) begin
        if (sb.size() == 0) chk("unexpected_event", 32'(act), 32'(0));
        else begin
          e = sb.pop_front();
          chk("event_kind", 32'(act), 32'(e.vec));
          chk("event_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  task automatic drive(input logic v, input logic e, input logic [7:0] d);
    @(posedge CLK); #1;
    RX_D_VLD = v; RX_ERR = e; RX_P_DATA = d;
  endtask

  task automatic send(input logic [7:0] b, input logic err = 1'b0, input int gap_n = 0);
    repeat (gap_n) drive(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
    drive(1'b1, err, b);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic do_reset();
    @(posedge CLK); #1;
    RST = 1'b1; RX_D_VLD = 1'b0; RX_ERR = 1'b0;
    @(posedge CLK); #1;
    chk("reset_outputs", 32'({WrEn, RdEn, ALU_EN, busy, frm_err, unk_cmd, Address, WrData, ALU_FUN}), 32'(0));
    RST = 1'b0;
  endtask

  initial begin
    int len, r, g;
    logic [7:0] op, ub;
    RST = 1'b1; RX_D_VLD = 1'b0; RX_ERR = 1'b0; RX_P_DATA = 8'h00;
    do_reset();
    idle(2);
    // Directed frames
    send(8'hAA); send(8'h05, 1'b0, 2); send(8'h3C, 1'b0, 3); idle(3);
    send(8'hBB); send(8'hF7); idle(2);
    send(8'hCC); send(8'h12); send(8'h34); send(8'h02);
    send(8'hDD); send(8'h08); idle(2);
    send(8'hAA); idle(20);
    send(8'hBB); send(8'h03); idle(2);
    send(8'hAA); send(8'h05); send(8'h99, 1'b1); idle(2);
    send(8'h55); idle(2);
    send(8'h55, 1'b1); idle(2);
    send(8'hCC); send(8'h12); do_reset();
    send(8'hCC); send(8'h01); send(8'h02); send(8'h03); idle(2);
    send(8'hBB); send(8'h0A, 1'b0, TO - 1); idle(2);
    send(8'hBB); send(8'h0B, 1'b0, TO); idle(2);
    // Random frames
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 19);
      if (r == 0) begin
        ub = 8'($urandom);
        if (ub inside {8'hAA, 8'hBB, 8'hCC, 8'hDD}) ub = 8'h00;
        send(ub, 1'b0, $urandom_range(0, 2));
      end else if (r == 1) begin
        do_reset();
      end else begin
        op  = (r < 7) ? 8'hAA : (r < 11) ? 8'hBB : (r < 16) ? 8'hCC : 8'hDD;
        len = (op == 8'hAA) ? 3 : (op == 8'hCC) ? 4 : 2;
        send(op, 1'b0, $urandom_range(0, 2));
        for (int k = 1; k < len; k++) begin
          g = ($urandom_range(0, 11) == 0) ? $urandom_range(TO - 1, TO) : $urandom_range(0, 3);
          send(8'($urandom), 1'($urandom_range(0, 19) == 0), g);
        end
      end
    end
    idle(40);
    chk("scoreboard_empty", 32'(sb.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
